// File: rtl/fetch_controller.sv
// Fetch sequencer: PC, 1-cycle memory read tracking, 2-entry in-order buffer to decode.
// First valid 2 cycles after reset/redirect; issue stalls once buffered+inflight reaches 2.
module fetch_controller #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] RESET_PC   = 32'd0
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic [31:0] AddressBus,
  input  logic [31:0] InstructionReg,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        decode_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  localparam logic [ADDR_WIDTH-1:0] RST_PC = RESET_PC[ADDR_WIDTH-1:0];

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]            count_q, count_d;
  logic [31:0]           instr0_q, instr0_d, instr1_q, instr1_d;
  logic [ADDR_WIDTH-1:0] epc0_q, epc0_d, epc1_q, epc1_d;

  logic       pop;
  logic       push;
  logic       stop_cap;
  logic       issue;
  logic [2:0] occ;
  logic       unused_redirect_hi;

  assign unused_redirect_hi = ^redirect_pc[31:ADDR_WIDTH];

  // A redirect cancels the pop: the head it would consume is wrong-path.
  assign pop      = (count_q != 2'd0) && decode_ready && !redirect_valid;
  assign push     = inflight_q && !redirect_valid;
  assign stop_cap = push && InstructionReg[0];
  assign occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue    = (state_q == RUN) && !redirect_valid && !stop_cap && (occ < 3'd2);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    instr0_d      = instr0_q;
    instr1_d      = instr1_q;
    epc0_d        = epc0_q;
    epc1_d        = epc1_q;

    if (redirect_valid) begin
      state_d    = RUN;
      pc_d       = redirect_pc[ADDR_WIDTH-1:0];
      inflight_d = 1'b0;
      count_d    = 2'd0;
    end else begin
      if (pop) begin
        instr0_d = instr1_q;
        epc0_d   = epc1_q;
      end
      // Push lands right behind whatever survives this cycle's pop.
      if (push) begin
        if ((count_q == 2'd0) || ((count_q == 2'd1) && pop)) begin
          instr0_d = InstructionReg;
          epc0_d   = inflight_pc_q;
        end else begin
          instr1_d = InstructionReg;
          epc1_d   = inflight_pc_q;
        end
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};

      inflight_d = issue;
      if (issue) begin
        inflight_pc_d = pc_q;
        pc_d          = pc_q + 1'b1;
      end

      // Stop word: discard the speculative issue and park pc just past it.
      if (stop_cap) begin
        state_d = DRAIN;
        pc_d    = inflight_pc_q + 1'b1;
      end

      if ((state_q == DRAIN) && pop && (count_q == 2'd1)) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      pc_q          <= RST_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      instr0_q      <= '0;
      instr1_q      <= '0;
      epc0_q        <= '0;
      epc1_q        <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      instr0_q      <= instr0_d;
      instr1_q      <= instr1_d;
      epc0_q        <= epc0_d;
      epc1_q        <= epc1_d;
    end
  end

  assign AddressBus  = 32'(pc_q);
  assign fetch_valid = (count_q != 2'd0);
  assign fetch_instr = instr0_q;
  assign fetch_pc    = 32'(epc0_q);
  assign halted      = (state_q == HALT);

endmodule
